// File: rtl/spiflash_reader.sv
// SPI flash (mode 0) single-word reader: issues 0x03 + 24-bit address, shifts in 32 data bits.
// Optional sequential-read continuation (chip select held between reads) with SPIFLASH_READER_SEQ_EN.
//
// state | meaning
// IDLE  | chip deselected, ready for a request
// SEL   | chip selected, one setup cycle before the first SPI clock
// SHIFT | 2 clk per bit: phase 0 clock low / MOSI update, phase 1 clock high
// DONE  | response pulse with the assembled word
// HOLD  | (SEQ_EN) chip still selected, ready; next sequential word needs no command
// DESEL | (SEQ_EN) one deselect cycle before restarting a non-sequential read
module spiflash_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        HOLD  = 3'd4,
        DESEL = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;
    logic [31:0] rx_word;
    logic [5:0]  bit_cnt;
    logic        phase;
`ifdef SPIFLASH_READER_SEQ_EN
    logic [23:0] addr_q;
`endif

    assign rx_word = {rx_sr[30:0], flash_io1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            phase     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            flash_csb <= 1'b1;
            flash_clk <= 1'b0;
            flash_io0 <= 1'b0;
`ifdef SPIFLASH_READER_SEQ_EN
            addr_q    <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tx_sr     <= {8'h03, req_addr};
                        bit_cnt   <= 6'd0;
                        req_ready <= 1'b0;
                        flash_csb <= 1'b0;
                        flash_clk <= 1'b0;
                        flash_io0 <= 1'b0;
                        state     <= SEL;
`ifdef SPIFLASH_READER_SEQ_EN
                        addr_q    <= req_addr;
`endif
                    end
                end
                SEL: begin
                    flash_csb <= 1'b0;
                    flash_clk <= 1'b0;
                    flash_io0 <= tx_sr[31];
                    tx_sr     <= {tx_sr[30:0], 1'b0};
                    phase     <= 1'b0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (!phase) begin
                        phase     <= 1'b1;
                        flash_clk <= 1'b1;
                    end else begin
                        phase     <= 1'b0;
                        flash_clk <= 1'b0;
                        rx_sr     <= rx_word;
                        if (bit_cnt == 6'd63) begin
                            // flash sends the byte at the lowest address first
                            rsp_data  <= {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
                            rsp_valid <= 1'b1;
                            flash_io0 <= 1'b0;
`ifndef SPIFLASH_READER_SEQ_EN
                            flash_csb <= 1'b1;
`endif
                            state     <= DONE;
                        end else begin
                            bit_cnt   <= bit_cnt + 6'd1;
                            flash_io0 <= tx_sr[31];
                            tx_sr     <= {tx_sr[30:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
`ifdef SPIFLASH_READER_SEQ_EN
                    state     <= HOLD;
`else
                    state     <= IDLE;
`endif
                end
`ifdef SPIFLASH_READER_SEQ_EN
                HOLD: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        req_ready <= 1'b0;
                        if (req_addr == addr_q + 24'd4) begin
                            // flash is still streaming; only the data phase is needed
                            tx_sr   <= '0;
                            bit_cnt <= 6'd32;
                            state   <= SEL;
                        end else begin
                            tx_sr     <= {8'h03, req_addr};
                            bit_cnt   <= 6'd0;
                            flash_csb <= 1'b1;
                            state     <= DESEL;
                        end
                    end
                end
                DESEL: begin
                    flash_csb <= 1'b0;
                    state     <= SEL;
                end
`endif
                default: begin
                    req_ready <= 1'b1;
                    flash_csb <= 1'b1;
                    flash_clk <= 1'b0;
                    flash_io0 <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spiflash_reader.sv
// Self-checking bench for spiflash_reader: behavioural mode-0 flash plus a response scoreboard.
// Adapts its latency/chip-select expectations when SPIFLASH_READER_SEQ_EN is defined.
module tb_spiflash_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        flash_csb;
    logic        flash_clk;
    logic        flash_io0;
    logic        flash_io1;

    always #5 clk = ~clk;

    spiflash_reader dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .flash_csb (flash_csb),
        .flash_clk (flash_clk),
        .flash_io0 (flash_io0),
        .flash_io1 (flash_io1)
    );

`ifdef SPIFLASH_READER_SEQ_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] fword(input logic [23:0] a);
        return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    // behavioural flash: samples MOSI on rising SCK, shifts MISO on falling SCK
    int          n = 0;
    logic        miso = 1'b0;
    logic [7:0]  cmd_sh = '0;
    logic [23:0] addr_sh = '0;
    logic [23:0] start = '0;
    logic [7:0]  cap_cmd = '0;
    logic [23:0] cap_addr = '0;
    bit          mosi_err = 1'b0;

    assign flash_io1 = miso;

    always @(posedge flash_csb) n = 0;

    always @(posedge flash_clk) begin
        if (!flash_csb) begin
            if (n < 8)       cmd_sh  = {cmd_sh[6:0], flash_io0};
            else if (n < 32) addr_sh = {addr_sh[22:0], flash_io0};
            else if (flash_io0 !== 1'b0) mosi_err = 1'b1;
            n++;
            if (n == 32) begin
                cap_cmd  = cmd_sh;
                cap_addr = addr_sh;
                start    = addr_sh;
            end
        end
    end

    always @(negedge flash_clk) begin
        int d;
        logic [7:0] b;
        if (!flash_csb && n >= 32) begin
            d    = n - 32;
            b    = fbyte(start + 24'(d / 8));
            miso = b[7 - (d % 8)];
        end
    end

    typedef struct {
        logic [23:0] addr;
        logic [31:0] data;
        int          lat;
        bit          full;
        int          csb_hi;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          hi_cnt = 0;
    int          rsp_cnt = 0;
    bit          busy = 1'b0;
    bit          in_hold = 1'b0;
    bit          hs_err = 1'b0;
    logic [23:0] last_a = '0;
    logic [31:0] last_rsp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (busy && req_ready) hs_err = 1'b1;
            if (busy && !rsp_valid && flash_csb) hi_cnt++;
            if (rsp_valid) begin
                rsp_cnt++;
                last_rsp = rsp_data;
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("data", 64'(rsp_data), 64'(e.data));
                    check("latency", 64'(cyc - acc_cyc + 1), 64'(e.lat));
                    check("csb_high_cycles", 64'(hi_cnt), 64'(e.csb_hi));
                    check("done_csb", 64'(flash_csb), 64'(!SEQ));
                    if (e.full) begin
                        check("mosi_cmd", 64'(cap_cmd), 64'h03);
                        check("mosi_addr", 64'(cap_addr), 64'(e.addr));
                    end
                end
                busy    = 1'b0;
                in_hold = SEQ;
            end
            if (req_valid && req_ready) begin
                e.addr   = req_addr;
                e.data   = fword(req_addr);
                e.lat    = 130;
                e.full   = 1'b1;
                e.csb_hi = 0;
                if (in_hold && req_addr == last_a + 24'd4) begin
                    e.lat  = 66;
                    e.full = 1'b0;
                end else if (in_hold) begin
                    e.lat    = 131;
                    e.csb_hi = 1;
                end
                sb.push_back(e);
                busy    = 1'b1;
                in_hold = 1'b0;
                acc_cyc = cyc + 1;
                hi_cnt  = 0;
                last_a  = req_addr;
            end
        end
    end

    task automatic issue(input logic [23:0] a, input int n_acc);
        int got = 0;
        int guard = 0;
        @(posedge clk);
        #2;
        req_addr  = a;
        req_valid = 1'b1;
        while (got < n_acc && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (req_ready) got++;
        end
        if (got < n_acc) check("accept_timeout", 64'(got), 64'(n_acc));
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        req_addr  = 24'($urandom);
    endtask

    task automatic wait_done();
        int g = 0;
        while ((busy || sb.size() != 0) && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (busy || sb.size() != 0) check("rsp_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        logic [23:0] a;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_csb", 64'(flash_csb), 64'd1);
        check("rst_sck", 64'(flash_clk), 64'd0);
        check("rst_mosi", 64'(flash_io0), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd1);

        // abort after SEL plus 40 SHIFT cycles
        rc = rsp_cnt;
        issue(24'h000300, 1);
        repeat (40) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        sb.delete();
        busy    = 1'b0;
        in_hold = 1'b0;
        @(negedge clk);
        check("abort_csb", 64'(flash_csb), 64'd1);
        check("abort_sck", 64'(flash_clk), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd1);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (150) @(negedge clk);
        check("abort_no_rsp", 64'(rsp_cnt - rc), 64'd0);

        issue(24'h000000, 1);
        wait_done();
        issue(24'h000100, 1);
        wait_done();
        check("single_read_word", 64'(last_rsp), 64'h44332211);
        issue(24'h000104, 1);
        wait_done();
        issue(24'h000000, 1);
        wait_done();
        issue(24'hFFFFFC, 1);
        wait_done();
        repeat (5) @(negedge clk);
        check("rsp_data_hold", 64'(rsp_data), 64'(fword(24'hFFFFFC)));

        rc = rsp_cnt;
        issue(24'h000200, 2);
        wait_done();
        check("one_rsp_per_accept", 64'(rsp_cnt - rc), 64'd2);

        a = 24'($urandom) & 24'hFFFFFC;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 1) a = a + 24'd4;
            else            a = 24'($urandom) & 24'hFFFFFC;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(a, 1);
            wait_done();
        end

        check("ready_low_while_busy", 64'(hs_err), 64'd0);
        check("mosi_zero_in_data", 64'(mosi_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spiflash_reader.md
SPIFLASH_READER -- requirements
Module: spiflash_reader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  read request present.
REQ-005 req_ready  out  1  request may be accepted this cycle.
REQ-006 req_addr  in  24  byte address of the 32-bit word to read.
REQ-007 rsp_valid  out  1  one-cycle pulse; rsp_data valid.
REQ-008 rsp_data  out  32  read word; byte at req_addr in [7:0], req_addr+3 in [31:24].
REQ-009 flash_csb  out  1  flash chip select, active low.
REQ-010 flash_clk  out  1  SPI clock, idle low (mode 0).
REQ-011 flash_io0  out  1  MOSI; command/address bits, MSB first.
REQ-012 flash_io1  in  1  MISO; data bits, MSB first per byte.

Function
REQ-013 States SHALL be IDLE, SEL, SHIFT, DONE (plus HOLD and DESEL when SEQ_EN is defined, see REQ-026..029).
REQ-014 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_ready SHALL be high only in IDLE (and HOLD).
REQ-015 On acceptance, req_addr SHALL be latched and the state SHALL go IDLE->SEL; later req_addr changes SHALL have no effect.
REQ-016 SEL SHALL last 1 cycle with flash_csb=0 and flash_clk=0; the next state is SHIFT.
REQ-017 SHIFT SHALL transfer 64 bits, 2 cycles per bit: phase 0 drives flash_clk=0 with flash_io0 updated, and phase 1 drives flash_clk=1.
REQ-018 flash_io1 SHALL be sampled on the rising clk edge that ends phase 1.
REQ-019 Bits 0-7 SHALL be command 0x03 and bits 8-31 SHALL be the latched address, both MSB first; during bits 32-63 flash_io0 SHALL be 0 and 32 data bits SHALL be shifted in.
REQ-020 After bit 63, the state SHALL go to DONE for 1 cycle with flash_csb=1, flash_clk=0, rsp_valid=1 and the assembled rsp_data; DONE->IDLE.
REQ-021 Latency SHALL be fixed: rsp_valid is high in the 130th cycle after the accept edge.
REQ-022 rsp_data SHALL hold its value until the next DONE; rsp_valid has no backpressure.
REQ-023 The address counter SHALL be 24-bit; 0xFFFFFD..0xFFFFFF reads SHALL be issued unmodified, and the flash defines the wrap.

Reset
REQ-024 On reset, the following SHALL hold on the next cycle, regardless of state:
- IDLE, flash_csb=1, flash_clk=0, flash_io0=0
- rsp_valid=0, rsp_data=0, req_ready=1
REQ-025 Reset mid-transaction SHALL abort without a rsp_valid pulse; the next request SHALL start a full command sequence.

Configuration
REQ-026 Macro SPIFLASH_READER_SEQ_EN SHALL enable sequential-read continuation; without it, behaviour SHALL be exactly REQ-013..025.
REQ-027 With SPIFLASH_READER_SEQ_EN, DONE SHALL keep flash_csb=0 and go to HOLD (flash_csb=0, flash_clk=0, req_ready=1) instead of IDLE.
REQ-028 In HOLD, if the accepted req_addr equals the last address+4 (mod 2^24), the block SHALL skip command/address and shift only bits 32-63; rsp_valid is then high in the 66th cycle after the accept edge.
REQ-029 In HOLD, a non-sequential accept SHALL go to DESEL (1 cycle, flash_csb=1), then SEL, and run the full sequence; rsp_valid is then high in the 131st cycle.

Verification
REQ-030 Single read: reset, request 0x000100 with the flash model holding bytes 0x11,0x22,0x33,0x44 -> MOSI stream 0x03,0x00,0x01,0x00; rsp_data=0x44332211; rsp_valid in cycle 130.
REQ-031 Handshake: hold req_valid through a transaction -> req_ready=0 from the accept edge until DONE; exactly one rsp_valid per accept.
REQ-032 Reset after 40 SHIFT cycles -> flash_csb=1 on the next cycle; no rsp_valid; a following read of 0x000000 returns the correct data.
REQ-033 Top address 0xFFFFFC -> address bits 0xFFFFFC on MOSI; rsp_data matches the model bytes.
REQ-034 SEQ_EN: read 0x000100 then 0x000104 -> the second response is in cycle 66 with no flash_csb rise between the reads; then read 0x000000 -> one flash_csb=1 cycle and a 131-cycle latency.
REQ-035 Without SEQ_EN: back-to-back reads 0x000100, 0x000104 -> flash_csb=1 in each DONE and both latencies are 130.
